// File: rtl/sram_pkg.sv
// Shared types, default geometry and address-width helpers for the SRAM write path.
package sram_pkg;

    localparam int DEF_ROWS   = 16;
    localparam int DEF_COLS   = 8;
    localparam int DEF_DATA_W = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } wr_state_t;

    function automatic int row_addr_w(input int rows);
        return $clog2(rows);
    endfunction

    function automatic int col_addr_w(input int cols);
        return $clog2(cols);
    endfunction

endpackage

// File: rtl/sram_onehot_dec.sv
// Binary-to-one-hot decoder with an in-range flag; out-of-range indices give all-zero.
module sram_onehot_dec #(
    parameter int N = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  onehot,
    output logic          valid
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign onehot[gi] = (idx == IW'(gi));
        end
    endgenerate

    // Extra bit keeps the compare correct when N is an exact power of two.
    assign valid = ({1'b0, idx} < (IW + 1)'(N));

endmodule

// File: rtl/sram_write_ctrl.sv
// Sequenced SRAM write controller: captures one request, then runs SETUP, a timed
// masked write pulse and HOLD, with one-hot row/column selects and a done/err pulse.
module sram_write_ctrl
    import sram_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int PULSE_CYCLES = 2,
    localparam int RA = row_addr_w(ROWS),
    localparam int CA = col_addr_w(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [RA+CA-1:0]  req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [DATA_W-1:0] req_mask,
    output logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   col_sel,
    output logic              do_write,
    output logic [DATA_W-1:0] data_bits,
    output logic [DATA_W-1:0] bit_en,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);

    wr_state_t     state_reg;
    logic [CW-1:0] cnt_reg;
    logic          addr_ok_reg;

    logic [ROWS-1:0] row_oh;
    logic [COLS-1:0] col_oh;
    logic            row_ok;
    logic            col_ok;
    logic            addr_ok;

    sram_onehot_dec #(.N(ROWS)) u_row_dec (
        .idx    (req_addr[CA +: RA]),
        .onehot (row_oh),
        .valid  (row_ok)
    );

    sram_onehot_dec #(.N(COLS)) u_col_dec (
        .idx    (req_addr[CA-1:0]),
        .onehot (col_oh),
        .valid  (col_ok)
    );

    assign addr_ok   = row_ok && col_ok;
    assign req_ready = (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_ok_reg <= 1'b0;
            row_sel     <= '0;
            col_sel     <= '0;
            do_write    <= 1'b0;
            data_bits   <= '0;
            bit_en      <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        // Both selects are suppressed if either half of the address is bad.
                        addr_ok_reg <= addr_ok;
                        row_sel     <= addr_ok ? row_oh : '0;
                        col_sel     <= addr_ok ? col_oh : '0;
                        data_bits   <= req_data;
                        bit_en      <= req_mask;
                        state_reg   <= SETUP;
                    end
                end
                SETUP: begin
                    if (addr_ok_reg && (|bit_en)) begin
                        do_write  <= 1'b1;
                        cnt_reg   <= CW'(PULSE_CYCLES);
                        state_reg <= PULSE;
                    end else begin
                        done      <= 1'b1;
                        err       <= ~addr_ok_reg;
                        state_reg <= HOLD;
                    end
                end
                PULSE: begin
                    if (cnt_reg == CW'(1)) begin
                        do_write  <= 1'b0;
                        done      <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                HOLD: begin
                    addr_ok_reg <= 1'b0;
                    row_sel     <= '0;
                    col_sel     <= '0;
                    data_bits   <= '0;
                    bit_en      <= '0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
